// File: rtl/chacha_wb_if.sv
// rtl/chacha_wb_if.sv - Wishbone register front end for a ChaCha keystream core
//
// Purpose:
//   Holds the key, nonce and block counter for a downstream ChaCha core.
//   Starts the core on request and captures the 16 keystream words it
//   returns. When a block is complete it advances the counter and can
//   raise a level interrupt.
//
// Ports:
//   wb_clk_i           single clock, rising edge
//   resetb             asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i   Wishbone classic slave request
//   wbs_ack_o/dat_o    Wishbone response (ack one cycle after request)
//   key_o/nonce_o/ctr_o  core parameters, straight from the registers
//   core_start_o       one-cycle start pulse to the core
//   core_word_valid_i/core_word_i  keystream words from the core, word 0 first
//   irq_o              block-ready interrupt (VALID & IRQ_EN, registered)
//
// Word map (byte offset from BASE_ADDR):
//   0x00 CTRL  [0] START (self-clearing), [1] IRQ_EN
//   0x04 STATUS [0] BUSY, [1] VALID (read-only)
//   0x10-0x2C KEY[0..7], 0x30 CTR, 0x34-0x3C NONCE[0..2], 0x40-0x7C OUT[0..15]

module chacha_wb_if #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic         wb_clk_i,
   input  logic         resetb,
   input  logic         wbs_cyc_i,
   input  logic         wbs_stb_i,
   input  logic         wbs_we_i,
   input  logic [3:0]   wbs_sel_i,
   input  logic [31:0]  wbs_adr_i,
   input  logic [31:0]  wbs_dat_i,
   output logic         wbs_ack_o,
   output logic [31:0]  wbs_dat_o,
   output logic [255:0] key_o,
   output logic [95:0]  nonce_o,
   output logic [31:0]  ctr_o,
   output logic         core_start_o,
   input  logic         core_word_valid_i,
   input  logic [31:0]  core_word_i,
   output logic         irq_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      READY = 2'd2
   } state_t;

   state_t state_q;
   state_t state_nx;

   logic [7:0][31:0]  key_q;
   logic [2:0][31:0]  nonce_q;
   logic [31:0]       ctr_q;
   logic [15:0][31:0] out_q;
   logic [3:0]        idx_q;
   logic              valid_q;
   logic              irq_en_q;

   logic              sel_hit;
   logic              accept;
   logic              wr;
   logic              rd;
   logic [5:0]        word_sel;
   logic              busy;
   logic              start_fire;
   logic              done_fire;
   logic              store_fire;
   logic [31:0]       rdata;
   logic              unused_ok;

   assign sel_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Blocking accept while ack is high gives the one-cycle gap between acks
   // for a request that is held across cycles.
   assign accept   = sel_hit & ~wbs_ack_o;
   assign wr       = accept & wbs_we_i;
   assign rd       = accept & ~wbs_we_i;
   assign word_sel = wbs_adr_i[7:2];
   assign busy     = (state_q == RUN);
   assign store_fire = busy & core_word_valid_i;

   assign key_o   = key_q;
   assign nonce_o = nonce_q;
   assign ctr_o   = ctr_q;

   assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:2]};

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return res;
   endfunction

   // Next-state logic. The write takes effect on the accepting edge, which
   // is the same edge that raises ack, so core_start_o is high in the ack cycle.
   always_comb begin
      state_nx   = state_q;
      start_fire = 1'b0;
      done_fire  = 1'b0;
      case (state_q)
         IDLE, READY: begin
            if (wr && (word_sel == 6'd0) && wbs_sel_i[0] && wbs_dat_i[0]) begin
               start_fire = 1'b1;
               state_nx   = RUN;
            end
         end
         RUN: begin
            if (core_word_valid_i && (idx_q == 4'd15)) begin
               done_fire = 1'b1;
               state_nx  = READY;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Read mux; OUT words are hidden until a full block is present.
   always_comb begin
      rdata = '0;
      if (word_sel[5:4] == 2'b01) begin
         if (valid_q) begin
            rdata = out_q[word_sel[3:0]];
         end
      end else if (word_sel[5:4] == 2'b00) begin
         case (word_sel[3:0])
            4'd0:  rdata = {30'd0, irq_en_q, 1'b0};
            4'd1:  rdata = {30'd0, valid_q, busy};
            4'd4:  rdata = key_q[0];
            4'd5:  rdata = key_q[1];
            4'd6:  rdata = key_q[2];
            4'd7:  rdata = key_q[3];
            4'd8:  rdata = key_q[4];
            4'd9:  rdata = key_q[5];
            4'd10: rdata = key_q[6];
            4'd11: rdata = key_q[7];
            4'd12: rdata = ctr_q;
            4'd13: rdata = nonce_q[0];
            4'd14: rdata = nonce_q[1];
            4'd15: rdata = nonce_q[2];
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= '0;
         core_start_o <= 1'b0;
         irq_o        <= 1'b0;
         key_q        <= '0;
         nonce_q      <= '0;
         ctr_q        <= '0;
         out_q        <= '0;
         idx_q        <= '0;
         valid_q      <= 1'b0;
         irq_en_q     <= 1'b0;
      end else begin
         wbs_ack_o    <= accept;
         wbs_dat_o    <= rd ? rdata : 32'd0;
         core_start_o <= start_fire;
         irq_o        <= valid_q & irq_en_q;

         if (wr && (word_sel == 6'd0) && wbs_sel_i[0]) begin
            irq_en_q <= wbs_dat_i[1];
         end

         // Parameter registers are frozen while the core is using them.
         if (wr && !busy && (word_sel[5:4] == 2'b00)) begin
            case (word_sel[3:0])
               4'd4:  key_q[0]   <= byte_merge(key_q[0], wbs_dat_i, wbs_sel_i);
               4'd5:  key_q[1]   <= byte_merge(key_q[1], wbs_dat_i, wbs_sel_i);
               4'd6:  key_q[2]   <= byte_merge(key_q[2], wbs_dat_i, wbs_sel_i);
               4'd7:  key_q[3]   <= byte_merge(key_q[3], wbs_dat_i, wbs_sel_i);
               4'd8:  key_q[4]   <= byte_merge(key_q[4], wbs_dat_i, wbs_sel_i);
               4'd9:  key_q[5]   <= byte_merge(key_q[5], wbs_dat_i, wbs_sel_i);
               4'd10: key_q[6]   <= byte_merge(key_q[6], wbs_dat_i, wbs_sel_i);
               4'd11: key_q[7]   <= byte_merge(key_q[7], wbs_dat_i, wbs_sel_i);
               4'd12: ctr_q      <= byte_merge(ctr_q, wbs_dat_i, wbs_sel_i);
               4'd13: nonce_q[0] <= byte_merge(nonce_q[0], wbs_dat_i, wbs_sel_i);
               4'd14: nonce_q[1] <= byte_merge(nonce_q[1], wbs_dat_i, wbs_sel_i);
               4'd15: nonce_q[2] <= byte_merge(nonce_q[2], wbs_dat_i, wbs_sel_i);
               default: ;
            endcase
         end

         if (start_fire) begin
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
         end

         if (store_fire) begin
            out_q[idx_q] <= core_word_i;
            idx_q        <= idx_q + 4'd1;
         end

         // Placed last so the counter increment overrides any CTR write.
         if (done_fire) begin
            valid_q <= 1'b1;
            ctr_q   <= ctr_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_chacha_wb_if.sv
// tb/tb_chacha_wb_if.sv - directed self-checking bench for chacha_wb_if

module tb_chacha_wb_if;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic         clk = 1'b0;
   logic         resetb = 1'b0;
   logic         cyc = 1'b0;
   logic         stb = 1'b0;
   logic         we = 1'b0;
   logic [3:0]   sel = 4'h0;
   logic [31:0]  adr = 32'h0;
   logic [31:0]  wdat = 32'h0;
   logic         ack;
   logic [31:0]  rdat;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  ctr;
   logic         core_start;
   logic         word_valid = 1'b0;
   logic [31:0]  word = 32'h0;
   logic         irq;

   int n_checks = 0;
   int n_fail = 0;
   int start_cnt = 0;

   always #5 clk = ~clk;

   chacha_wb_if #(.BASE_ADDR(BASE)) dut (
      .wb_clk_i          (clk),
      .resetb            (resetb),
      .wbs_cyc_i         (cyc),
      .wbs_stb_i         (stb),
      .wbs_we_i          (we),
      .wbs_sel_i         (sel),
      .wbs_adr_i         (adr),
      .wbs_dat_i         (wdat),
      .wbs_ack_o         (ack),
      .wbs_dat_o         (rdat),
      .key_o             (key),
      .nonce_o           (nonce),
      .ctr_o             (ctr),
      .core_start_o      (core_start),
      .core_word_valid_i (word_valid),
      .core_word_i       (word),
      .irq_o             (irq)
   );

   always @(negedge clk) begin
      if (core_start) start_cnt++;
   end

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic got_ack;
      got_ack = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = be;
      for (int i = 0; i < 8 && !got_ack; i++) begin
         @(posedge clk); #1;
         if (ack) got_ack = 1'b1;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got_ack) check_eq("wb_write_ack_timeout", 0, 1);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      logic got_ack;
      got_ack = 1'b0;
      d = 32'hX;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      for (int i = 0; i < 8 && !got_ack; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got_ack = 1'b1;
            d = rdat;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      if (!got_ack) check_eq("wb_read_ack_timeout", 0, 1);
   endtask

   task automatic feed(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         word_valid = 1'b1;
         word = base + 32'(i);
      end
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   logic [31:0]  rv;
   logic [255:0] exp_key;
   int           acks;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ack", ack, 0);
      check_eq("rst_dat", rdat, 0);
      check_eq("rst_start", core_start, 0);
      check_eq("rst_irq", irq, 0);
      check_eq("rst_key", key, 0);
      check_eq("rst_ctr", ctr, 0);
      resetb = 1'b1;
      wb_read(BASE + 32'h04, rv); check_eq("rst_status", rv, 0);
      wb_read(BASE + 32'h00, rv); check_eq("rst_ctrl", rv, 0);

      // Program key, nonce, counter
      for (int i = 0; i < 8; i++) begin
         exp_key[i*32 +: 32] = 32'h0302_0100 + 32'(i) * 32'h0404_0404;
         wb_write(BASE + 32'h10 + 32'(4*i), exp_key[i*32 +: 32], 4'hF);
      end
      wb_write(BASE + 32'h34, 32'h0900_0000, 4'hF);
      wb_write(BASE + 32'h38, 32'h4A00_0000, 4'hF);
      wb_write(BASE + 32'h3C, 32'h0000_0000, 4'hF);
      wb_write(BASE + 32'h30, 32'h1122_3344, 4'hF);
      wb_write(BASE + 32'h30, 32'h0000_00FF, 4'b0001);
      wb_read(BASE + 32'h30, rv); check_eq("ctr_byte_sel", rv, 32'h1122_33FF);
      wb_write(BASE + 32'h30, 32'h0000_0001, 4'hF);
      check_eq("key_o", key, exp_key);
      check_eq("nonce_o", nonce, {32'h0, 32'h4A00_0000, 32'h0900_0000});
      check_eq("ctr_o", ctr, 1);
      wb_read(BASE + 32'h1C, rv); check_eq("key3_read", rv, 32'h0F0E_0D0C);
      wb_read(BASE + 32'h08, rv); check_eq("unmapped_08", rv, 0);

      // Start, and check write blocking while busy
      wb_write(BASE + 32'h00, 32'h1, 4'hF);
      repeat (2) @(negedge clk);
      check_eq("start_pulses_1", start_cnt, 1);
      wb_read(BASE + 32'h04, rv); check_eq("status_busy", rv, 1);
      wb_read(BASE + 32'h40, rv); check_eq("out_hidden", rv, 0);
      wb_write(BASE + 32'h1C, 32'hDEAD_BEEF, 4'hF);
      wb_read(BASE + 32'h1C, rv); check_eq("key3_locked", rv, 32'h0F0E_0D0C);
      wb_write(BASE + 32'h00, 32'h1, 4'hF);
      repeat (2) @(negedge clk);
      check_eq("start_ignored_busy", start_cnt, 1);

      // Complete the block
      feed(16, 32'hA0);
      wb_read(BASE + 32'h04, rv); check_eq("status_valid", rv, 2);
      wb_read(BASE + 32'h30, rv); check_eq("ctr_incr", rv, 2);
      for (int i = 0; i < 16; i++) begin
         wb_read(BASE + 32'h40 + 32'(4*i), rv);
         check_eq($sformatf("out%0d", i), rv, 32'hA0 + 32'(i));
      end
      wb_read(BASE + 32'h80, rv); check_eq("unmapped_80", rv, 0);

      // Interrupt and counter wrap
      wb_write(BASE + 32'h00, 32'h2, 4'hF);
      repeat (2) @(negedge clk);
      check_eq("irq_set", irq, 1);
      wb_read(BASE + 32'h00, rv); check_eq("ctrl_read", rv, 2);
      wb_write(BASE + 32'h30, 32'hFFFF_FFFF, 4'hF);
      wb_write(BASE + 32'h00, 32'h3, 4'hF);
      @(posedge clk); #1;
      check_eq("irq_cleared", irq, 0);
      wb_read(BASE + 32'h04, rv); check_eq("status_restart", rv, 1);
      check_eq("start_pulses_2", start_cnt, 2);
      feed(16, 32'h100);
      repeat (2) @(negedge clk);
      check_eq("irq_again", irq, 1);
      wb_read(BASE + 32'h30, rv); check_eq("ctr_wrap", rv, 0);
      check_eq("ctr_o_wrap", ctr, 0);

      // Held read: ack every second cycle
      repeat (2) @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04;
      #1 check_eq("held_ack0", ack, 0);
      @(negedge clk); check_eq("held_ack1", ack, 1);
      @(negedge clk); check_eq("held_ack2", ack, 0);
      @(negedge clk); check_eq("held_ack3", ack, 1);
      cyc = 1'b0; stb = 1'b0;
      repeat (2) @(negedge clk);
      acks = 0;
      cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      check_eq("unselected_acks", acks, 0);

      // Reset during a block
      wb_write(BASE + 32'h00, 32'h1, 4'hF);
      feed(7, 32'h200);
      @(negedge clk);
      resetb = 1'b0;
      #1;
      check_eq("mid_rst_ack", ack, 0);
      check_eq("mid_rst_dat", rdat, 0);
      check_eq("mid_rst_start", core_start, 0);
      check_eq("mid_rst_irq", irq, 0);
      check_eq("mid_rst_key", key, 0);
      check_eq("mid_rst_nonce", nonce, 0);
      @(negedge clk);
      resetb = 1'b1;
      feed(9, 32'h207);
      wb_read(BASE + 32'h04, rv); check_eq("post_rst_status", rv, 0);
      wb_read(BASE + 32'h40, rv); check_eq("post_rst_out0", rv, 0);
      wb_read(BASE + 32'h60, rv); check_eq("post_rst_out8", rv, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
